ser_rx8_deser: RTL and testbench

- Serial-in / parallel-out frame receiver. It is the receive end of the team's 8-bit parallel-load / serial-shift transmitter register.
- Accepts one bit per sample strobe, frames on start/stop bits, optionally checks parity, and presents the assembled byte through a valid/ready holding register.
- Sits between the serial link pin and the byte-wide consumer logic. Reports parity, framing and overrun status as sticky flags.

---
 rtl/ser_link_pkg.sv | 21 ++
 rtl/ser_rx8_outbuf.sv | 54 +++++
 rtl/ser_rx8_deser.sv | 123 ++++++++++++
 tb/tb_ser_rx8_deser.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ser_link_pkg.sv
// rtl/ser_link_pkg.sv - shared serial-link frame format, state encoding and parity helper
package ser_link_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ser_state_e;

    localparam int   DATA_W_DEFAULT = 8;
    localparam logic IDLE_LEVEL     = 1'b1;
    localparam logic START_LEVEL    = 1'b0;
    localparam logic STOP_LEVEL     = 1'b1;

    // Parity bit for a frame; narrower frames are zero-extended by the caller.
    function automatic logic parity_bit(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/ser_rx8_outbuf.sv
// rtl/ser_rx8_outbuf.sv - single-entry valid/ready holding register with sticky overrun
module ser_rx8_outbuf #(
    parameter int DATA_W = 8
) (
    input  logic              CK,
    input  logic              RN,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              dout_ready,
    input  logic              clr_flags,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              overrun
);

    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              ovr_q, ovr_d;
    logic              accept;
    logic              can_load;

    assign accept   = valid_q & dout_ready;
    assign can_load = ~valid_q | accept;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (load_valid && can_load) begin
            data_d  = load_data;
            valid_d = 1'b1;
        end else if (accept) begin
            valid_d = 1'b0;
        end
        // A new event in the clear cycle must still be recorded.
        ovr_d = (load_valid & ~can_load) | (ovr_q & ~clr_flags);
    end

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign dout       = data_q;
    assign dout_valid = valid_q;
    assign overrun    = ovr_q;

endmodule

// File: rtl/ser_rx8_deser.sv
// rtl/ser_rx8_deser.sv - start/stop framed serial receiver with parity check and byte output buffer
module ser_rx8_deser
    import ser_link_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEFAULT,
    parameter bit PARITY_EN  = 1'b1,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic              CK,
    input  logic              RN,
    input  logic              bit_en,
    input  logic              sdi,
    input  logic              lsb_first,
    input  logic              clr_flags,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              busy,
    output logic              par_err,
    output logic              frm_err,
    output logic              overrun
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    ser_state_e        state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              lsbf_q, lsbf_d;
    logic              par_q, par_d;
    logic              perr_q, perr_d;
    logic              par_err_q, par_err_d;
    logic              frm_err_q, frm_err_d;
    logic              frame_done;
    logic              exp_par;

    assign exp_par = parity_bit({7'b0, par_q}, PARITY_ODD);

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        cnt_d      = cnt_q;
        lsbf_d     = lsbf_q;
        par_d      = par_q;
        perr_d     = perr_q;
        frame_done = 1'b0;
        if (bit_en) begin
            case (state_q)
                IDLE: begin
                    if (sdi == START_LEVEL) begin
                        state_d = DATA;
                        lsbf_d  = lsb_first;
                        cnt_d   = '0;
                        par_d   = 1'b0;
                        perr_d  = 1'b0;
                    end
                end
                DATA: begin
                    // LSB-first frames fill from the top so the first bit ends in bit 0.
                    shreg_d = lsbf_q ? {sdi, shreg_q[DATA_W-1:1]}
                                     : {shreg_q[DATA_W-2:0], sdi};
                    par_d   = par_q ^ sdi;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        state_d = PARITY_EN ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    perr_d  = (sdi != exp_par);
                    state_d = STOP;
                end
                STOP: begin
                    frame_done = 1'b1;
                    state_d    = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
        par_err_d = (frame_done & perr_q) | (par_err_q & ~clr_flags);
        frm_err_d = (frame_done & (sdi != STOP_LEVEL)) | (frm_err_q & ~clr_flags);
    end

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            cnt_q     <= '0;
            lsbf_q    <= 1'b0;
            par_q     <= 1'b0;
            perr_q    <= 1'b0;
            par_err_q <= 1'b0;
            frm_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            cnt_q     <= cnt_d;
            lsbf_q    <= lsbf_d;
            par_q     <= par_d;
            perr_q    <= perr_d;
            par_err_q <= par_err_d;
            frm_err_q <= frm_err_d;
        end
    end

    ser_rx8_outbuf #(
        .DATA_W(DATA_W)
    ) u_outbuf (
        .CK         (CK),
        .RN         (RN),
        .load_valid (frame_done),
        .load_data  (shreg_q),
        .dout_ready (dout_ready),
        .clr_flags  (clr_flags),
        .dout       (dout),
        .dout_valid (dout_valid),
        .overrun    (overrun)
    );

    assign busy    = (state_q != IDLE);
    assign par_err = par_err_q;
    assign frm_err = frm_err_q;

endmodule

// File: tb/tb_ser_rx8_deser.sv
// tb/tb_ser_rx8_deser.sv - scoreboard bench for ser_rx8_deser with a frame-level reference model
module tb_ser_rx8_deser;

    localparam int W   = 8;
    localparam bit ODD = 1'b0;

    logic         CK = 1'b0;
    logic         RN = 1'b0;
    logic         bit_en = 1'b0;
    logic         sdi = 1'b1;
    logic         lsb_first = 1'b1;
    logic         clr_flags = 1'b0;
    logic         dout_ready = 1'b0;
    logic [W-1:0] dout;
    logic         dout_valid;
    logic         busy;
    logic         par_err;
    logic         frm_err;
    logic         overrun;

    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] exp_q[$];
    logic         m_par = 1'b0;
    logic         m_frm = 1'b0;
    logic         m_ovr = 1'b0;
    int           ready_mode = 0;
    bit           mon_en = 1'b0;

    always #5 CK = ~CK;

    ser_rx8_deser #(
        .DATA_W    (W),
        .PARITY_EN (1'b1),
        .PARITY_ODD(ODD)
    ) dut (
        .CK        (CK),
        .RN        (RN),
        .bit_en    (bit_en),
        .sdi       (sdi),
        .lsb_first (lsb_first),
        .clr_flags (clr_flags),
        .dout      (dout),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready),
        .busy      (busy),
        .par_err   (par_err),
        .frm_err   (frm_err),
        .overrun   (overrun)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    // Monitor: model state vs DUT every cycle, and pop the scoreboard on each accept.
    always @(negedge CK) begin
        if (mon_en) begin
            check("valid_vs_model", dout_valid, exp_q.size() > 0);
            check("par_err", par_err, m_par);
            check("frm_err", frm_err, m_frm);
            check("overrun", overrun, m_ovr);
            if (dout_valid && dout_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte actual=%0h required=none", dout);
                end else begin
                    check("dout", dout, exp_q.pop_front());
                end
            end
        end
    end

    task automatic drive_cycle(input bit en, input logic b, input bit is_stop);
        @(posedge CK);
        #1;
        bit_en = en;
        sdi    = en ? b : 1'($urandom_range(0, 1));
        case (ready_mode)
            0:       dout_ready = 1'b1;
            1:       dout_ready = 1'b0;
            2:       dout_ready = 1'($urandom_range(0, 1));
            default: dout_ready = is_stop;
        endcase
    endtask

    task automatic idle(input int n);
        repeat (n) drive_cycle(1'b0, 1'b0, 1'b0);
    endtask

    task automatic strobe(input logic b, input int gmin, input int gmax, input bit is_stop);
        int g;
        g = gmin + int'($urandom_range(0, gmax - gmin));
        repeat (g) drive_cycle(1'b0, 1'b0, 1'b0);
        drive_cycle(1'b1, b, is_stop);
    endtask

    // Sends one frame; ends inside the stop cycle after the model has taken its decision.
    task automatic send_frame(input logic [W-1:0] d, input bit lsbf, input bit inj,
                              input logic stopb, input int gmin, input int gmax);
        logic pb;
        lsb_first = ~lsbf;
        strobe(1'b0, gmin, gmax, 1'b0);
        lsb_first = lsbf;
        for (int i = 0; i < W; i++) begin
            strobe(lsbf ? d[i] : d[W-1-i], gmin, gmax, 1'b0);
            lsb_first = ~lsbf;
        end
        pb = (^d) ^ ODD ^ inj;
        strobe(pb, gmin, gmax, 1'b0);
        strobe(stopb, gmin, gmax, 1'b1);
        @(negedge CK);
        #1;
        if (inj)    m_par = 1'b1;
        if (!stopb) m_frm = 1'b1;
        if (exp_q.size() > 0) m_ovr = 1'b1;
        else                  exp_q.push_back(d);
    endtask

    task automatic clear_flags();
        drive_cycle(1'b0, 1'b0, 1'b0);
        clr_flags = 1'b1;
        @(negedge CK);
        #1;
        m_par = 1'b0;
        m_frm = 1'b0;
        m_ovr = 1'b0;
        drive_cycle(1'b0, 1'b0, 1'b0);
        clr_flags = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge CK);
        #1;
        check("rst_dout", dout, 0);
        check("rst_valid", dout_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_flags", {par_err, frm_err, overrun}, 0);
        RN = 1'b1;
        mon_en = 1'b1;
        idle(2);

        // Basic LSB-first frame, held so the output can be inspected.
        ready_mode = 1;
        send_frame(8'hA5, 1'b1, 1'b0, 1'b1, 1, 1);
        idle(1);
        check("a5_dout", dout, 8'hA5);
        check("a5_valid", dout_valid, 1);
        ready_mode = 0;
        idle(2);

        // MSB-first, then a wrong parity bit, then clear.
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 0, 1);
        idle(2);
        send_frame(8'h01, 1'b0, 1'b1, 1'b1, 0, 1);
        idle(2);
        check("perr_set", par_err, 1);
        clear_flags();
        idle(1);
        check("perr_clr", par_err, 0);

        // Framing error followed by a back-to-back good frame.
        send_frame(8'h55, 1'b1, 1'b0, 1'b0, 0, 1);
        send_frame(8'h9A, 1'b1, 1'b0, 1'b1, 0, 0);
        idle(2);
        check("frm_set", frm_err, 1);
        clear_flags();

        // Overrun: second byte dropped while the first is held.
        ready_mode = 1;
        send_frame(8'h11, 1'b1, 1'b0, 1'b1, 0, 1);
        send_frame(8'h22, 1'b1, 1'b0, 1'b1, 0, 1);
        idle(2);
        check("ovr_dout", dout, 8'h11);
        check("ovr_flag", overrun, 1);
        ready_mode = 0;
        idle(1);
        ready_mode = 1;
        idle(2);
        check("ovr_drained", dout_valid, 0);

        // Reset in the middle of a frame.
        ready_mode = 0;
        lsb_first = 1'b1;
        strobe(1'b0, 1, 1, 1'b0);
        for (int i = 0; i < 4; i++) strobe(1'b1, 0, 1, 1'b0);
        @(negedge CK);
        check("mid_busy", busy, 1);
        drive_cycle(1'b0, 1'b0, 1'b0);
        RN = 1'b0;
        exp_q.delete();
        m_par = 1'b0;
        m_frm = 1'b0;
        m_ovr = 1'b0;
        @(negedge CK);
        check("rst2_busy", busy, 0);
        check("rst2_dout", dout, 0);
        idle(2);
        RN = 1'b1;
        send_frame(8'h0F, 1'b1, 1'b0, 1'b1, 0, 1);
        idle(2);

        // Strobe gaps plus same-cycle accept and load.
        ready_mode = 1;
        send_frame(8'h5A, 1'b1, 1'b0, 1'b1, 3, 3);
        idle(1);
        ready_mode = 3;
        send_frame(8'hC3, 1'b0, 1'b0, 1'b1, 3, 3);
        idle(1);
        check("sc_dout", dout, 8'hC3);
        check("sc_valid", dout_valid, 1);
        check("sc_ovr", overrun, 0);
        ready_mode = 0;
        idle(2);

        // Randomized frames against the model.
        ready_mode = 2;
        for (int n = 0; n < 40; n++) begin
            send_frame(W'($urandom), 1'($urandom_range(0, 1)),
                       ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) != 0), 0, 2);
            idle(int'($urandom_range(0, 2)));
            if ($urandom_range(0, 7) == 0) clear_flags();
        end

        ready_mode = 0;
        idle(5);
        check("drain_empty", exp_q.size(), 0);
        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
